fp32_addsub_pipe: RTL and testbench

//  Pipelined, multi-lane IEEE-754 binary32 add/subtract with valid/ready flow control.

---
 rtl/fp32_addsub_pipe_if.sv | 26 ++
 rtl/fp32_addsub_pipe.sv | 182 ++++++++++++++++++
 tb/tb_fp32_addsub_pipe.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_addsub_pipe_if.sv
// rtl/fp32_addsub_pipe_if.sv - valid/ready beat interface for the pipelined fp32 add/sub
interface fp32_addsub_pipe_if #(
    parameter int LANES = 1,
    parameter int TAG_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [32*LANES-1:0] in_a;
    logic [32*LANES-1:0] in_b;
    logic [LANES-1:0]    in_sub;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [32*LANES-1:0] out_data;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/fp32_addsub_pipe.sv
// rtl/fp32_addsub_pipe.sv - 4-stage multi-lane IEEE-754 binary32 add/subtract, FTZ, RNE
module fp32_addsub_pipe #(
    parameter int LANES = 1,
    parameter int TAG_W = 8
) (
    input logic               clk,
    input logic               rst,
    fp32_addsub_pipe_if.slave bus
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int k = 0; k < 27; k++) begin
            if (v[k]) lzc27 = 5'(26 - k);
        end
    endfunction

    logic                v1, v2, v3, v4;
    logic [TAG_W-1:0]    tag1, tag2, tag3, tag4;
    logic                advance;
    logic [32*LANES-1:0] data4;

    // All stages move in lockstep; a stalled output freezes the whole pipe.
    assign advance       = !v4 || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v4;
    assign bus.out_tag   = tag4;
    assign bus.out_data  = data4;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            v4   <= 1'b0;
            tag1 <= '0;
            tag2 <= '0;
            tag3 <= '0;
            tag4 <= '0;
        end else if (advance) begin
            v1   <= bus.in_valid;
            v2   <= v1;
            v3   <= v2;
            v4   <= v3;
            tag1 <= bus.in_tag;
            tag2 <= tag1;
            tag3 <= tag2;
            tag4 <= tag3;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0] a, b;
        logic        sb_eff, a_nan, b_nan, a_inf, b_inf, a_big;
        logic        nan0, inf0, inf_sign0;
        logic [30:0] a_mag, b_mag, mag_l, mag_s;

        logic        s1_sign_l, s1_sign_s, s1_nan, s1_inf, s1_inf_sign;
        logic [7:0]  s1_exp_l, s1_exp_s;
        logic [23:0] s1_man_l, s1_man_s;

        logic [7:0]  diff;
        logic [4:0]  shamt;
        logic [53:0] wide;
        logic [26:0] man_s_al;

        logic        s2_sign, s2_sub, s2_nan, s2_inf, s2_inf_sign;
        logic [7:0]  s2_exp;
        logic [26:0] s2_man_l, s2_man_s;

        logic [27:0]       sum;
        logic [4:0]        lz;
        logic [26:0]       norm;
        logic signed [9:0] exp_n;

        logic              s3_sign, s3_zero, s3_nan, s3_inf, s3_inf_sign;
        logic signed [9:0] s3_exp;
        logic [26:0]       s3_norm;

        logic              rnd_up;
        logic [24:0]       mant;
        logic signed [9:0] exp_r;
        logic [31:0]       res, s4_res;

        assign a = bus.in_a[32*i +: 32];
        assign b = bus.in_b[32*i +: 32];
        assign data4[32*i +: 32] = s4_res;

        // Stage 1: classify, flush subnormals, order operands by magnitude.
        always_comb begin
            sb_eff    = b[31] ^ bus.in_sub[i];
            a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
            b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
            a_inf     = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
            b_inf     = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
            a_mag     = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
            b_mag     = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
            a_big     = a_mag >= b_mag;
            mag_l     = a_big ? a_mag : b_mag;
            mag_s     = a_big ? b_mag : a_mag;
            nan0      = a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff));
            inf0      = a_inf || b_inf;
            inf_sign0 = a_inf ? a[31] : sb_eff;
        end

        // Stage 2: align the smaller operand; anything shifted out folds into sticky.
        always_comb begin
            diff     = s1_exp_l - s1_exp_s;
            shamt    = (diff > 8'd27) ? 5'd27 : diff[4:0];
            wide     = {s1_man_s, 30'd0} >> shamt;
            man_s_al = {wide[53:28], wide[27] | (|wide[26:0])};
        end

        // Stage 3: magnitude add/sub then normalise so the hidden bit sits at bit 26.
        always_comb begin
            sum = s2_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                         : ({1'b0, s2_man_l} + {1'b0, s2_man_s});
            lz  = lzc27(sum[26:0]);
            if (sum[27]) begin
                norm  = {sum[27:2], sum[1] | sum[0]};
                exp_n = $signed({2'b00, s2_exp}) + 10'sd1;
            end else begin
                norm  = sum[26:0] << lz;
                exp_n = $signed({2'b00, s2_exp}) - $signed({5'd0, lz});
            end
        end

        // Stage 4: round to nearest even and resolve specials/overflow/underflow.
        always_comb begin
            rnd_up = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
            mant   = {1'b0, s3_norm[26:3]} + {24'd0, rnd_up};
            exp_r  = s3_exp + (mant[24] ? 10'sd1 : 10'sd0);
            if (s3_nan)
                res = 32'h7FC0_0000;
            else if (s3_inf)
                res = {s3_inf_sign, 8'hFF, 23'd0};
            else if (s3_zero || exp_r <= 10'sd0)
                res = {s3_sign, 31'd0};
            else if (exp_r >= 10'sd255)
                res = {s3_sign, 8'hFF, 23'd0};
            else
                res = {s3_sign, exp_r[7:0], mant[24] ? mant[23:1] : mant[22:0]};
        end

        always_ff @(posedge clk) begin
            if (rst)
                s4_res <= '0;
            else if (advance)
                s4_res <= res;

            if (advance) begin
                s1_sign_l   <= a_big ? a[31] : sb_eff;
                s1_sign_s   <= a_big ? sb_eff : a[31];
                s1_exp_l    <= mag_l[30:23];
                s1_exp_s    <= mag_s[30:23];
                s1_man_l    <= {mag_l[30:23] != 8'd0, mag_l[22:0]};
                s1_man_s    <= {mag_s[30:23] != 8'd0, mag_s[22:0]};
                s1_nan      <= nan0;
                s1_inf      <= inf0;
                s1_inf_sign <= inf_sign0;

                s2_sign     <= s1_sign_l;
                s2_sub      <= s1_sign_l ^ s1_sign_s;
                s2_exp      <= s1_exp_l;
                s2_man_l    <= {s1_man_l, 3'b000};
                s2_man_s    <= man_s_al;
                s2_nan      <= s1_nan;
                s2_inf      <= s1_inf;
                s2_inf_sign <= s1_inf_sign;

                s3_zero     <= (sum == 28'd0);
                s3_sign     <= (sum == 28'd0) ? (s2_sign & ~s2_sub) : s2_sign;
                s3_exp      <= exp_n;
                s3_norm     <= norm;
                s3_nan      <= s2_nan;
                s3_inf      <= s2_inf;
                s3_inf_sign <= s2_inf_sign;
            end
        end
    end

endmodule

// File: tb/tb_fp32_addsub_pipe.sv
// tb/tb_fp32_addsub_pipe.sv - randomized scoreboard bench for fp32_addsub_pipe against a real-arithmetic model
module tb_fp32_addsub_pipe;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int NDIR  = 12;

    typedef struct {
        logic [32*LANES-1:0] data;
        logic [TAG_W-1:0]    tag;
    } beat_t;

    logic clk, rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    beat_t sb[$];
    beat_t mon_exp;
    bit   rdy_rand   = 1'b0;
    bit   stall_prev = 1'b0;
    logic [32*LANES-1:0] prev_data;
    logic [TAG_W-1:0]    prev_tag;
    logic [31:0] dir_a [NDIR];
    logic [31:0] dir_b [NDIR];
    logic [31:0] dir_r [NDIR];
    logic        dir_s [NDIR];

    fp32_addsub_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

    fp32_addsub_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic real to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    // Exact double sum, then round-to-nearest-even into binary32 with FTZ.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb;
        real         rs;
        logic [63:0] d;
        int          e;
        logic [22:0] frac;
        logic [28:0] rem;
        logic [23:0] fr24;
        logic        up, a_nan, b_nan, a_inf, b_inf;
        bb    = {b[31] ^ sub, b[30:0]};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] == bb[31]) ? a : 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return bb;
        rs = to_real(a) + to_real(bb);
        if (rs == 0.0) return {a[31] & bb[31], 31'd0};
        d = $realtobits(rs);
        e = int'(d[62:52]) - 896;
        if (e < 1) return {d[63], 31'd0};
        frac = d[51:29];
        rem  = d[28:0];
        up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && frac[0]);
        fr24 = {1'b0, frac} + {23'd0, up};
        if (fr24[23]) e = e + 1;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), fr24[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 15);
        r = $urandom;
        case (k)
            0: r[30:23] = 8'hFF;
            1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2: r[30:23] = 8'h00;
            3: r[30:0] = other[30:0];
            4, 5, 6, 7: r[30:23] = other[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
            8: r[30:0] = 31'h7F7F_FFFF - (r[30:0] & 31'h3FF);
            9: r[30:23] = 8'($urandom_range(1, 3));
            default: ;
        endcase
        return r;
    endfunction

    // Every beat accepted is scored; every beat emitted must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 128'(bus.out_valid), 128'd1);
                check("stall_data", 128'(bus.out_data), 128'(prev_data));
                check("stall_tag", 128'(bus.out_tag), 128'(prev_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 128'(bus.out_data), 128'd0);
                    n_fail += (bus.out_data == '0) ? 1 : 0;
                end else begin
                    mon_exp = sb.pop_front();
                    check("beat_data", 128'(bus.out_data), 128'(mon_exp.data));
                    check("beat_tag", 128'(bus.out_tag), 128'(mon_exp.tag));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int i = 0; i < LANES; i++)
                    mon_exp.data[32*i +: 32] = ref_add(bus.in_a[32*i +: 32], bus.in_b[32*i +: 32], bus.in_sub[i]);
                mon_exp.tag = bus.in_tag;
                sb.push_back(mon_exp);
            end
            stall_prev <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
            prev_tag   <= bus.out_tag;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic send_beat(input logic [32*LANES-1:0] a, input logic [32*LANES-1:0] b,
                             input logic [LANES-1:0] sub, input logic [TAG_W-1:0] tag);
        int guard;
        guard      = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_tag   = tag;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail_timeout("in_ready_wait");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_dir(input int k, input logic [TAG_W-1:0] tag);
        logic [32*LANES-1:0] a, b;
        logic [LANES-1:0]    s;
        for (int i = 0; i < LANES; i++) begin
            a[32*i +: 32] = dir_a[(k + i) % NDIR];
            b[32*i +: 32] = dir_b[(k + i) % NDIR];
            s[i]          = dir_s[(k + i) % NDIR];
        end
        send_beat(a, b, s, tag);
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag);
        logic [32*LANES-1:0] a, b;
        logic [LANES-1:0]    s;
        for (int i = 0; i < LANES; i++) begin
            a[32*i +: 32] = $urandom;
            a[32*i +: 32] = rand_fp(a[32*i +: 32]);
            b[32*i +: 32] = rand_fp(a[32*i +: 32]);
            s[i]          = 1'($urandom_range(0, 1));
        end
        send_beat(a, b, s, tag);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_sub   = '0;
        bus.in_tag   = '0;

        dir_a[0]  = 32'h3F80_0000; dir_b[0]  = 32'h4000_0000; dir_s[0]  = 0; dir_r[0]  = 32'h4040_0000;
        dir_a[1]  = 32'h3F80_0000; dir_b[1]  = 32'h3F80_0000; dir_s[1]  = 1; dir_r[1]  = 32'h0000_0000;
        dir_a[2]  = 32'h8000_0000; dir_b[2]  = 32'h8000_0000; dir_s[2]  = 0; dir_r[2]  = 32'h8000_0000;
        dir_a[3]  = 32'h3F80_0000; dir_b[3]  = 32'h3380_0000; dir_s[3]  = 0; dir_r[3]  = 32'h3F80_0000;
        dir_a[4]  = 32'h3F80_0001; dir_b[4]  = 32'h3380_0000; dir_s[4]  = 0; dir_r[4]  = 32'h3F80_0002;
        dir_a[5]  = 32'h7F7F_FFFF; dir_b[5]  = 32'h7F7F_FFFF; dir_s[5]  = 0; dir_r[5]  = 32'h7F80_0000;
        dir_a[6]  = 32'h7F80_0000; dir_b[6]  = 32'h7F80_0000; dir_s[6]  = 1; dir_r[6]  = 32'h7FC0_0000;
        dir_a[7]  = 32'h0000_0001; dir_b[7]  = 32'h0000_0000; dir_s[7]  = 0; dir_r[7]  = 32'h0000_0000;
        dir_a[8]  = 32'h7F80_0000; dir_b[8]  = 32'h3F80_0000; dir_s[8]  = 0; dir_r[8]  = 32'h7F80_0000;
        dir_a[9]  = 32'h4040_0000; dir_b[9]  = 32'h3F80_0000; dir_s[9]  = 1; dir_r[9]  = 32'h4000_0000;
        dir_a[10] = 32'h0080_0001; dir_b[10] = 32'h0080_0000; dir_s[10] = 1; dir_r[10] = 32'h0000_0000;
        dir_a[11] = 32'h7F80_0001; dir_b[11] = 32'h3F80_0000; dir_s[11] = 0; dir_r[11] = 32'h7FC0_0000;

        for (int k = 0; k < NDIR; k++)
            check($sformatf("model_vec%0d", k), 128'(ref_add(dir_a[k], dir_b[k], dir_s[k])), 128'(dir_r[k]));

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", 128'(bus.out_data), 128'd0);
        check("rst_out_tag", 128'(bus.out_tag), 128'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;

        // Latency of a lone beat on an idle, never-stalled pipe.
        send_dir(0, 8'hA5);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t1_latency", 128'(lat), 128'd4);
        check("t1_data", 128'(bus.out_data[31:0]), 128'h4040_0000);
        check("t1_tag", 128'(bus.out_tag), 128'hA5);

        for (int k = 1; k < NDIR; k++) send_dir(k, 8'(k));
        drain();

        rdy_rand = 1'b1;
        for (int n = 0; n < 1000; n++) send_rand(8'(n));
        rdy_rand = 1'b0;
        drain();
        check("all_beats_emitted", 128'(sb.size()), 128'd0);

        // Reset with three beats in flight: none may surface afterwards.
        for (int k = 0; k < 3; k++) send_rand(8'(8'hF0 + k));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_out_valid", 128'(bus.out_valid), 128'd0);
        check("t6_out_data", 128'(bus.out_data), 128'd0);
        check("t6_out_tag", 128'(bus.out_tag), 128'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t6_quiet_%0d", c), 128'(bus.out_valid), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
